// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    localparam logic       OWN_INST  = 1'b0;
    localparam logic       OWN_DATA  = 1'b1;
    localparam logic [3:0] STRB_NONE = 4'b0000;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// One req/addr_ok/data_ok channel; instantiated for fetch, load/store and memory sides.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [3:0]        strb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (output req, wr, strb, addr, wdata, input addr_ok, data_ok, rdata);
    modport slave  (input req, wr, strb, addr, wdata, output addr_ok, data_ok, rdata);
    // Fetch never writes, so its slave view carries no write payload.
    modport fetch_slave (input req, addr, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive data wins over a waiting fetch; force_inst hands the next
// contended grant to the fetch side once the limit is reached.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic force_inst
);
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Next count: clear on fetch grant, saturating increment on a data win.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr) begin
            cnt_nxt_s = CNT_W'(0);
        end else if (inc && (cnt_r != LIMIT)) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= CNT_W'(0);
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    // A limit of zero disables forcing entirely.
    always_comb begin
        if ((STARVE_LIMIT != 0) && (cnt_r == LIMIT)) begin
            force_inst = 1'b1;
        end else begin
            force_inst = 1'b0;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like port between fetch and load/store, one transaction at a time;
// data wins contention unless the starvation guard forces a fetch grant.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    mem_port_arbiter_if.fetch_slave inst_bus,
    mem_port_arbiter_if.slave       data_bus,
    mem_port_arbiter_if.master      mem_bus,
    output logic                    busy,
    output logic                    owner,
    output logic                    proto_err
);
    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    logic              owner_r;
    logic              wr_r;
    logic [3:0]        strb_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              proto_err_r;

    logic              grant_inst_s;
    logic              grant_data_s;
    logic              proto_set_s;
    logic              force_inst_s;

    mem_arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .inc        (grant_data_s & inst_bus.req),
        .clr        (grant_inst_s),
        .force_inst (force_inst_s)
    );

    // Grant decision, memory drive and response steering.
    always_comb begin
        state_nxt_s      = state_r;
        grant_inst_s     = 1'b0;
        grant_data_s     = 1'b0;
        proto_set_s      = 1'b0;
        inst_bus.addr_ok = 1'b0;
        inst_bus.data_ok = 1'b0;
        inst_bus.rdata   = {DATA_W{1'b0}};
        data_bus.addr_ok = 1'b0;
        data_bus.data_ok = 1'b0;
        data_bus.rdata   = {DATA_W{1'b0}};
        mem_bus.req      = 1'b0;
        mem_bus.wr       = 1'b0;
        mem_bus.strb     = STRB_NONE;
        mem_bus.addr     = {ADDR_W{1'b0}};
        mem_bus.wdata    = {DATA_W{1'b0}};

        case (state_r)
            ARB_IDLE: begin
                // Gated by rst so no addr_ok leaks out while the arbiter is held in reset.
                if (!rst && data_bus.req && !(inst_bus.req && force_inst_s)) begin
                    grant_data_s = 1'b1;
                end else if (!rst && inst_bus.req) begin
                    grant_inst_s = 1'b1;
                end else begin
                    grant_inst_s = 1'b0;
                end
                if (grant_data_s || grant_inst_s) begin
                    state_nxt_s = ARB_ADDR;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
                inst_bus.addr_ok = grant_inst_s;
                data_bus.addr_ok = grant_data_s;
                proto_set_s      = mem_bus.data_ok | mem_bus.addr_ok;
            end
            ARB_ADDR: begin
                mem_bus.req   = 1'b1;
                mem_bus.wr    = wr_r;
                mem_bus.strb  = strb_r;
                mem_bus.addr  = addr_r;
                mem_bus.wdata = wdata_r;
                proto_set_s   = mem_bus.data_ok;
                if (mem_bus.addr_ok) begin
                    state_nxt_s = ARB_RESP;
                end else begin
                    state_nxt_s = ARB_ADDR;
                end
            end
            ARB_RESP: begin
                proto_set_s = mem_bus.addr_ok;
                if (mem_bus.data_ok) begin
                    state_nxt_s = ARB_IDLE;
                    if (owner_r == OWN_DATA) begin
                        data_bus.data_ok = 1'b1;
                        data_bus.rdata   = mem_bus.rdata;
                    end else begin
                        inst_bus.data_ok = 1'b1;
                        inst_bus.rdata   = mem_bus.rdata;
                    end
                end else begin
                    state_nxt_s = ARB_RESP;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // State, latched request payload and sticky protocol-error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ARB_IDLE;
            owner_r     <= OWN_INST;
            wr_r        <= 1'b0;
            strb_r      <= STRB_NONE;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            proto_err_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (grant_data_s) begin
                owner_r <= OWN_DATA;
                wr_r    <= data_bus.wr;
                strb_r  <= data_bus.wr ? data_bus.strb : STRB_NONE;
                addr_r  <= data_bus.addr;
                wdata_r <= data_bus.wdata;
            end else if (grant_inst_s) begin
                owner_r <= OWN_INST;
                wr_r    <= 1'b0;
                strb_r  <= STRB_NONE;
                addr_r  <= inst_bus.addr;
                wdata_r <= {DATA_W{1'b0}};
            end else begin
                owner_r <= owner_r;
            end
            if (proto_set_s) begin
                proto_err_r <= 1'b1;
            end else begin
                proto_err_r <= proto_err_r;
            end
        end
    end

    assign busy      = (state_r != ARB_IDLE);
    assign owner     = owner_r;
    assign proto_err = proto_err_r;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one SRAM-like memory port between the instruction-fetch requester and the load/store requester of the 5-stage MIPS pipeline. Both requesters use a req/addr_ok/data_ok handshake. Data requests win by default; a starvation guard bounds how long instruction fetch can be locked out. The block holds one outstanding transaction at a time and sits between the core's IF/EX memory interfaces and the external memory port.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
STARVE_LIMIT, 4, consecutive data wins over a pending inst_req before inst is forced to win; 0 = strict data priority

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
inst_req  in  1  fetch request; held until inst_addr_ok
inst_addr  in  ADDR_W  fetch address
inst_addr_ok  out  1  one-cycle pulse: fetch accepted
inst_data_ok  out  1  one-cycle pulse: inst_rdata valid
inst_rdata  out  DATA_W  fetch data
data_req  in  1  load/store request; held until data_addr_ok
data_wr  in  1  1 = store, 0 = load
data_strb  in  4  byte strobes for stores
data_addr  in  ADDR_W  load/store address
data_wdata  in  DATA_W  store data
data_addr_ok  out  1  one-cycle pulse: load/store accepted
data_data_ok  out  1  one-cycle pulse: load data valid / store done
data_rdata  out  DATA_W  load data
mem_req  out  1  memory request
mem_wr  out  1  memory write
mem_strb  out  4  memory byte strobes
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_addr_ok  in  1  memory accepted the request
mem_data_ok  in  1  memory response
mem_rdata  in  DATA_W  memory read data
busy  out  1  transaction in flight (state != IDLE)
owner  out  1  current owner: 0 = inst, 1 = data
proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs 0. Latched request and starvation counter cleared. proto_err cleared. An in-flight transaction is abandoned; no data_ok is issued for it.
- States: IDLE -> ADDR -> RESP -> IDLE.
- IDLE, grant decision:
  - No req: stay in IDLE.
  - Only one req: grant it.
  - Both req: data wins, unless STARVE_LIMIT!=0 and starve_cnt==STARVE_LIMIT, in which case inst wins.
  - On grant: pulse the winner's *_addr_ok in the same cycle (combinational). Latch addr, wr, strb and wdata (inst: wr=0, strb=0, wdata=0). Set owner. Go to ADDR.
  - For a load, the latched strb is 0.
- ADDR: mem_req=1 and mem_* driven from the latched registers. Stay until mem_addr_ok=1, then go to RESP.
- RESP: mem_req=0. Wait for mem_data_ok.
  - On mem_data_ok: owner's *_data_ok=1 and *_rdata=mem_rdata in the same cycle (combinational pass-through), then go to IDLE.
  - Both *_rdata read 0 when the matching *_data_ok is 0.
- Throughput: minimum 3 cycles per transaction (grant, addr, resp). A requester's next req is sampled in the IDLE cycle after data_ok.
- Starvation counter:
  - Increments in an IDLE grant cycle where inst_req=1 and data wins. Saturates at STARVE_LIMIT.
  - Clears when inst is granted.
  - Holds otherwise, including cycles where inst_req=0.
- Protocol error: proto_err sets and stays set (until reset) on:
  - mem_data_ok=1 in IDLE or ADDR;
  - mem_addr_ok=1 outside ADDR.
  - The offending pulse is otherwise ignored, with no state change.
- Requesters must hold req and payload stable until addr_ok. The arbiter latches on grant, so changes after addr_ok are harmless.
- Simultaneous inst_req and data_req at reset release: the first IDLE cycle with rst=0 grants data (starve_cnt=0).

Decomposition:
- Package mem_arb_pkg:
  - state encoding (ARB_IDLE, ARB_ADDR, ARB_RESP);
  - owner constants OWN_INST=0, OWN_DATA=1;
  - strobe constant STRB_NONE=4'b0000.
- One sub-module, mem_arb_starve_ctr: saturating counter plus the force_inst output; parameter STARVE_LIMIT.
- FSM, latches and response steering stay in the top.

Test Plan:
- Single fetch: inst_req, addr=0xBFC00000, addr_ok next cycle, data_ok 2 cycles later with 0x3C1D0001 -> inst_addr_ok pulses in cycle 0; mem_req high for exactly 1 cycle with mem_wr=0, mem_strb=0; inst_data_ok pulses with inst_rdata=0x3C1D0001; data_data_ok never pulses.
- Store: data_req, wr=1, strb=4'b0011, addr=0x80001004, wdata=0xDEADBEEF -> mem_addr=0x80001004, mem_wr=1, mem_strb=4'b0011, mem_wdata=0xDEADBEEF; data_data_ok pulses once; no inst_* pulses.
- Contention: both req held continuously, STARVE_LIMIT=4, zero-wait memory -> grant order D,D,D,D,I,D,D,D,D,I. Repeat with STARVE_LIMIT=0 -> inst never granted while data_req stays high.
- Memory stall: hold mem_addr_ok=0 for 5 cycles -> mem_req and mem_addr stay stable for all 5 cycles; a new inst_req during the stall gets no addr_ok until after the current data_ok.
- Protocol error: mem_data_ok pulse in IDLE -> proto_err=1 next cycle and stays 1; state stays IDLE; no *_data_ok pulses.
- Reset mid-transaction: rst asserted in RESP -> all outputs 0 immediately, state=IDLE. A mem_data_ok after release sets proto_err and is not forwarded.
